// File: rtl/cube_pkg.sv
// Move codes and helpers shared by the move sequencer and the 2x2 cube controller.
package cube_pkg;

  localparam logic [3:0] MV_R        = 4'd0;
  localparam logic [3:0] MV_R_PRIME  = 4'd1;
  localparam logic [3:0] MV_F        = 4'd2;
  localparam logic [3:0] MV_F_PRIME  = 4'd3;
  localparam logic [3:0] MV_U        = 4'd4;
  localparam logic [3:0] MV_U_PRIME  = 4'd5;
  localparam logic [3:0] MV_L        = 4'd6;
  localparam logic [3:0] MV_L_PRIME  = 4'd7;
  localparam logic [3:0] MV_X        = 4'd8;
  localparam logic [3:0] MV_X_PRIME  = 4'd9;
  localparam logic [3:0] MV_Y        = 4'd10;
  localparam logic [3:0] MV_Y_PRIME  = 4'd11;
  localparam logic [3:0] MV_Z        = 4'd12;
  localparam logic [3:0] MV_Z_PRIME  = 4'd13;
  localparam logic [3:0] CMD_NONE    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } seq_state_t;

  function automatic logic is_move(input logic [3:0] code);
    return code <= MV_Z_PRIME;
  endfunction

  // A move and its prime differ only in the LSB.
  function automatic logic [3:0] inv_move(input logic [3:0] code);
    return code ^ 4'b0001;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO for queued moves; head is presented combinationally on dout.
module move_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign dout   = r_mem[r_rd];
  assign w_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/move_sequencer.sv
// Queues keypad moves and issues them as single-cycle strobes spaced by a settle gap.
// Optional undo history enabled by defining MOVE_SEQ_UNDO_EN.
module move_sequencer
  import cube_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 10_000_000,
  parameter int unsigned HIST_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_cmd,
  input  logic       enable,
  input  logic       flush,
  input  logic       undo_req,
  output logic [3:0] command,
  output logic       ischanged,
  output logic       busy,
  output logic       fifo_full,
  output logic       drop_err
);

  localparam int unsigned CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

`ifdef MOVE_SEQ_UNDO_EN
  localparam int unsigned FW = 5;
`else
  localparam int unsigned FW = 4;
`endif

  seq_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_cmd, w_cmd_nxt;
  logic          r_chg, w_chg_nxt;
  logic          r_busy;
  logic          r_drop;

  logic          w_push, w_pop, w_full, w_empty, w_drop;
  logic [FW-1:0] w_din, w_dout;

  assign w_pop = (r_state == ST_IDLE) && enable && !w_empty && !flush;

`ifdef MOVE_SEQ_UNDO_EN
  localparam int unsigned HW = $clog2(HIST_DEPTH);

  logic [3:0]  r_hist [HIST_DEPTH];
  logic [HW-1:0] r_hptr;
  logic [HW:0] r_hcnt;
  logic [HW-1:0] w_hprev;
  logic [3:0]  w_htop;
  logic        w_hempty, w_undo_ok, w_key_ok, w_rec;

  assign w_hprev   = r_hptr - 1'b1;
  assign w_htop    = r_hist[w_hprev];
  assign w_hempty  = (r_hcnt == '0);
  assign w_undo_ok = undo_req && !flush && !w_hempty && !w_full;
  assign w_key_ok  = key_valid && !undo_req && !flush && is_move(key_cmd) && (!w_full || w_pop);
  assign w_push    = w_undo_ok || w_key_ok;
  // Bit 4 tags undo-generated entries so they are not re-recorded when issued.
  assign w_din     = w_undo_ok ? {1'b1, inv_move(w_htop)} : {1'b0, key_cmd};
  assign w_rec     = w_pop && !w_dout[4];
  assign w_drop    = !flush && ((undo_req && (w_hempty || w_full || key_valid)) ||
                                (key_valid && !undo_req && !w_key_ok));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_hptr <= '0;
      r_hcnt <= '0;
    end else begin
      // Simultaneous issue and undo: the popped top slot is reused for the new record.
      case ({w_rec, w_undo_ok})
        2'b10: begin
          r_hist[r_hptr] <= w_dout[3:0];
          r_hptr         <= r_hptr + 1'b1;
          if (r_hcnt != (HW+1)'(HIST_DEPTH)) r_hcnt <= r_hcnt + 1'b1;
        end
        2'b01: begin
          r_hptr <= w_hprev;
          r_hcnt <= r_hcnt - 1'b1;
        end
        2'b11:   r_hist[w_hprev] <= w_dout[3:0];
        default: r_hcnt <= r_hcnt;
      endcase
    end
  end
`else
  logic w_unused_undo;

  assign w_unused_undo = undo_req | (HIST_DEPTH == 0);
  assign w_push = key_valid && !flush && is_move(key_cmd) && (!w_full || w_pop);
  assign w_din  = key_cmd;
  assign w_drop = key_valid && !flush && !w_push;
`endif

  move_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cmd_nxt   = r_cmd;
    w_chg_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_nxt = ST_ISSUE;
          w_cmd_nxt   = w_dout[3:0];
          w_chg_nxt   = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt   = GAP_LOAD;
        w_state_nxt = flush ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (flush || r_cnt == '0) w_state_nxt = ST_IDLE;
        else                      w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cmd   <= CMD_NONE;
      r_chg   <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cmd   <= w_cmd_nxt;
      r_chg   <= w_chg_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_drop  <= w_drop;
    end
  end

  assign command   = r_cmd;
  assign ischanged = r_chg;
  assign busy      = r_busy;
  assign fifo_full = w_full;
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed scenarios plus randomized traffic vs a queue model.
module tb_move_sequencer;

  localparam int DEPTH = 4;
  localparam int GAP   = 4;
  localparam int HIST  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_cmd = 4'h0;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       undo_req = 1'b0;
  logic [3:0] command;
  logic       ischanged, busy, fifo_full, drop_err;

  int total = 0;
  int bad   = 0;

  // Reference model state: move queue (bit 4 = undo-generated), history, cycles until next issue.
  int         mq[$];
  int         hq[$];
  int         cool = 0;
  logic [3:0] e_cmd = 4'hF;
  logic       e_chg = 1'b0, e_busy = 1'b0, e_drop = 1'b0, e_full = 1'b0;

  always #5 clk = ~clk;

  move_sequencer #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .HIST_DEPTH (HIST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_cmd   (key_cmd),
    .enable    (enable),
    .flush     (flush),
    .undo_req  (undo_req),
    .command   (command),
    .ischanged (ischanged),
    .busy      (busy),
    .fifo_full (fifo_full),
    .drop_err  (drop_err)
  );

  task automatic model_step();
    int v;
    int rec;
    bit full_pre;
    if (rst) begin
      mq.delete(); hq.delete(); cool = 0;
      e_cmd = 4'hF; e_chg = 0; e_busy = 0; e_drop = 0; e_full = 0;
      return;
    end
    rec = -1;
    full_pre = (mq.size() == DEPTH);
    e_chg = 0;
    e_drop = 0;
    if (cool == 0 && enable && mq.size() > 0 && !flush) begin
      v = mq.pop_front();
      e_cmd = 4'(v & 15);
      e_chg = 1;
      cool = GAP + 1;
      if (v < 16) rec = v;
    end else if (cool > 0) begin
      cool = flush ? 0 : cool - 1;
    end
    e_busy = (cool > 0);
    if (flush) begin
      mq.delete();
      hq.delete();
    end else begin
`ifdef MOVE_SEQ_UNDO_EN
      if (undo_req) begin
        if (hq.size() == 0 || full_pre) e_drop = 1;
        else begin
          v = hq.pop_back();
          mq.push_back((v ^ 1) + 16);
        end
        if (key_valid) e_drop = 1;
      end else if (key_valid) begin
        if (key_cmd > 13 || mq.size() >= DEPTH) e_drop = 1;
        else mq.push_back(int'(key_cmd));
      end
`else
      if (key_valid) begin
        if (key_cmd > 13 || mq.size() >= DEPTH) e_drop = 1;
        else mq.push_back(int'(key_cmd));
      end
`endif
      if (rec >= 0) begin
        hq.push_back(rec);
        if (hq.size() > HIST) void'(hq.pop_front());
      end
    end
    e_full = (mq.size() == DEPTH);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    flush     = 1'b0;
    undo_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    repeat (10) cyc();
    total++; if (command !== 4'hF) begin bad++; $display("FAIL reset_command got=%h exp=f", command); end
    total++; if (ischanged !== 1'b0) begin bad++; $display("FAIL reset_ischanged got=%b exp=0", ischanged); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_fifo_full got=%b exp=0", fifo_full); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL reset_drop_err got=%b exp=0", drop_err); end
  endtask

  task automatic test_latency();
    enable = 1'b1;
    key_valid = 1'b1; key_cmd = 4'h0;
    cyc();
    total++; if (ischanged !== 1'b0) begin bad++; $display("FAIL lat_c1_strobe got=%b exp=0", ischanged); end
    cyc();
    total++; if (ischanged !== 1'b1) begin bad++; $display("FAIL lat_c2_strobe got=%b exp=1", ischanged); end
    total++; if (command !== 4'h0) begin bad++; $display("FAIL lat_c2_command got=%h exp=0", command); end
    cyc();
    total++; if (ischanged !== 1'b0) begin bad++; $display("FAIL lat_c3_strobe got=%b exp=0", ischanged); end
    for (int i = 0; i < 20 && busy; i++) cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lat_idle_timeout busy=%b exp=0", busy); end
    total++; if (command !== 4'h0) begin bad++; $display("FAIL lat_command_held got=%h exp=0", command); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [3:0] keys [3];
    logic [3:0] held;
    logic       exp_chg;
    keys[0] = 4'h4; keys[1] = 4'h2; keys[2] = 4'h6;
    held = 4'h0;
    enable = 1'b1;
    for (int c = 0; c < 19; c++) begin
      if (c < 3) begin key_valid = 1'b1; key_cmd = keys[c]; end
      cyc();
      exp_chg = (c + 1 == 2) || (c + 1 == 8) || (c + 1 == 14);
      if (c + 1 == 2)  held = 4'h4;
      if (c + 1 == 8)  held = 4'h2;
      if (c + 1 == 14) held = 4'h6;
      total++;
      if (ischanged !== exp_chg) begin
        bad++; $display("FAIL b2b_strobe cycle=%0d got=%b exp=%b", c + 1, ischanged, exp_chg);
      end
      total++;
      if (command !== held) begin
        bad++; $display("FAIL b2b_command cycle=%0d got=%h exp=%h", c + 1, command, held);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_c19 got=%b exp=0", busy); end
  endtask

  task automatic test_full_drop();
    bit seen;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1; key_cmd = 4'($urandom_range(0, 13));
      cyc();
      if (i < 3) begin
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL full_early i=%0d got=%b exp=0", i, fifo_full); end
      end
      if (i == 3) begin
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL full_after4 got=%b exp=1", fifo_full); end
        total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL full_nodrop4 got=%b exp=0", drop_err); end
      end
      if (i == 4) begin
        total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL full_drop5 got=%b exp=1", drop_err); end
      end
    end
    flush = 1'b1;
    cyc();
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL flush_empty fifo_full=%b exp=0", fifo_full); end
    enable = 1'b1;
    seen = 0;
    repeat (10) begin cyc(); if (ischanged) seen = 1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_strobe got=%b exp=0", seen); end
  endtask

  task automatic test_bad_codes();
    bit seen;
    enable = 1'b1;
    key_valid = 1'b1; key_cmd = 4'hE;
    cyc();
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL bad_code_e got=%b exp=1", drop_err); end
    key_valid = 1'b1; key_cmd = 4'hF;
    cyc();
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL bad_code_f got=%b exp=1", drop_err); end
    seen = 0;
    repeat (8) begin cyc(); if (ischanged) seen = 1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL bad_code_strobe got=%b exp=0", seen); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL bad_code_full got=%b exp=0", fifo_full); end
  endtask

  task automatic test_undo();
    bit         seen;
    logic [3:0] got;
    enable = 1'b1;
    flush = 1'b1;
    cyc(); cyc();
`ifdef MOVE_SEQ_UNDO_EN
    key_valid = 1'b1; key_cmd = 4'h0; cyc();
    key_valid = 1'b1; key_cmd = 4'h2; cyc();
    repeat (20) cyc();
    for (int u = 0; u < 2; u++) begin
      undo_req = 1'b1;
      seen = 0; got = 4'hF;
      for (int i = 0; i < 10 && !seen; i++) begin
        cyc();
        if (ischanged) begin seen = 1; got = command; end
      end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL undo%0d_strobe_timeout got=%b exp=1", u, seen); end
      total++;
      if (got !== ((u == 0) ? 4'h3 : 4'h1)) begin
        bad++; $display("FAIL undo%0d_command got=%h exp=%h", u, got, (u == 0) ? 4'h3 : 4'h1);
      end
      for (int i = 0; i < 20 && busy; i++) cyc();
    end
    undo_req = 1'b1;
    cyc();
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL undo_empty_drop got=%b exp=1", drop_err); end
    seen = 0;
    repeat (8) begin cyc(); if (ischanged) seen = 1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL undo_empty_strobe got=%b exp=0", seen); end
`else
    key_valid = 1'b1; key_cmd = 4'h0; cyc();
    repeat (12) cyc();
    seen = 0;
    for (int u = 0; u < 3; u++) begin
      undo_req = 1'b1;
      cyc();
      if (ischanged) seen = 1;
      total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL undo_off_drop%0d got=%b exp=0", u, drop_err); end
    end
    repeat (8) begin cyc(); if (ischanged) seen = 1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL undo_off_strobe got=%b exp=0", seen); end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      enable    = ($urandom_range(0, 9) < 8);
      key_valid = ($urandom_range(0, 9) < 4);
      key_cmd   = 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 39) == 0);
      undo_req  = ($urandom_range(0, 19) == 0);
      cyc();
      total++; if (command !== e_cmd) begin bad++; $display("FAIL rnd_command n=%0d got=%h exp=%h", n, command, e_cmd); end
      total++; if (ischanged !== e_chg) begin bad++; $display("FAIL rnd_ischanged n=%0d got=%b exp=%b", n, ischanged, e_chg); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, e_busy); end
      total++; if (fifo_full !== e_full) begin bad++; $display("FAIL rnd_fifo_full n=%0d got=%b exp=%b", n, fifo_full, e_full); end
      total++; if (drop_err !== e_drop) begin bad++; $display("FAIL rnd_drop_err n=%0d got=%b exp=%b", n, drop_err, e_drop); end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_full_drop();
    test_bad_codes();
    test_undo();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
